// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the phase sequencer and its controller:
// phase numbering, sequencer state encoding and opcodes.
package phase_sequencer_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned STATE_W = 2;

    localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] STORE      = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

endpackage

// File: rtl/phase_sequencer_sat_counter.sv
// Enable-increment counter that sticks at its all-ones maximum.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] MAX_COUNT = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_COUNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/phase_sequencer.sv
// Eight-phase instruction sequencer with memory stalls, halt at the
// operand-address phase, single-step and a saturating retired count.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             mem_ready,
    input  logic             run_req,
    input  logic             step_req,
    output logic [WIDTH-1:0] phase,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       r_state;
    logic [WIDTH-1:0] r_phase;
    logic             r_halted;
    logic             r_instr_done;

    logic w_running;
    logic w_stall;
    logic w_halt_take;
    logic w_resume;
    logic w_advance;
    logic w_wrap;

    assign w_running   = (r_state != ST_HALTED);
    assign w_stall     = ((r_phase == WIDTH'(INST_FETCH)) || (r_phase == WIDTH'(OP_FETCH)))
                         && !mem_ready;
    assign w_halt_take = w_running && (r_phase == WIDTH'(OP_ADDR)) && halt;
    assign w_resume    = !w_running && (run_req || step_req);
    assign w_advance   = (w_running && !w_halt_take && !w_stall) || w_resume;
    assign w_wrap      = w_advance && (r_phase == WIDTH'(STORE));

    // Halt wins over stall at phase 4; resume advances on the same edge it is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_phase      <= '0;
            r_halted     <= 1'b0;
            r_instr_done <= 1'b0;
        end else begin
            r_instr_done <= w_wrap;
            case (r_state)
                ST_HALTED: begin
                    if (run_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                        r_phase  <= r_phase + WIDTH'(1);
                    end else if (step_req) begin
                        r_state  <= ST_STEP;
                        r_halted <= 1'b0;
                        r_phase  <= r_phase + WIDTH'(1);
                    end
                end
                default: begin
                    if (w_halt_take) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                        r_phase  <= WIDTH'(OP_FETCH);
                    end else if (!w_stall) begin
                        r_phase <= r_phase + WIDTH'(1);
                        if ((r_phase == WIDTH'(STORE)) && (r_state == ST_STEP)) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retired (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_wrap),
        .o_count (retired)
    );

    assign phase      = r_phase;
    assign halted     = r_halted;
    assign instr_done = r_instr_done;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a phase/mode/wrap-count model
// checked every cycle, plus literal expectations along a directed sequence.
module tb_phase_sequencer;

    localparam int M_RUN  = 0;
    localparam int M_STEP = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        mem_ready;
    logic        run_req;
    logic        step_req;
    logic [2:0]  phase;
    logic        halted;
    logic        instr_done;
    logic [15:0] retired;
    logic [2:0]  phase2;
    logic        halted2;
    logic        instr_done2;
    logic [1:0]  retired2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int ph;
        int mode;
        int wraps;
        bit done;
    } mdl_t;

    mdl_t m = '{0, M_RUN, 0, 1'b0};

    always #5 clk = ~clk;

    phase_sequencer #(.WIDTH(3), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .mem_ready  (mem_ready),
        .run_req    (run_req),
        .step_req   (step_req),
        .phase      (phase),
        .halted     (halted),
        .instr_done (instr_done),
        .retired    (retired)
    );

    // Narrow counter instance so saturation is reachable in a few instructions.
    phase_sequencer #(.WIDTH(3), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .mem_ready  (mem_ready),
        .run_req    (run_req),
        .step_req   (step_req),
        .phase      (phase2),
        .halted     (halted2),
        .instr_done (instr_done2),
        .retired    (retired2)
    );

    function automatic mdl_t step_model(mdl_t cur, bit h, bit mr, bit rr, bit sr);
        mdl_t nxt;
        bit   go;
        nxt      = cur;
        nxt.done = 1'b0;
        go       = 1'b0;
        if (cur.mode == M_HALT) begin
            if (rr) begin
                nxt.mode = M_RUN;
                go = 1'b1;
            end else if (sr) begin
                nxt.mode = M_STEP;
                go = 1'b1;
            end
        end else if (cur.ph == 4 && h) begin
            nxt.ph   = 5;
            nxt.mode = M_HALT;
        end else if (!((cur.ph == 1 || cur.ph == 5) && !mr)) begin
            go = 1'b1;
        end
        if (go) begin
            nxt.ph = (cur.ph + 1) % 8;
            if (nxt.ph == 0) begin
                nxt.wraps = cur.wraps + 1;
                nxt.done  = 1'b1;
                if (nxt.mode == M_STEP) nxt.mode = M_HALT;
            end
        end
        return nxt;
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{0, M_RUN, 0, 1'b0};
        else      m <= step_model(m, halt, mem_ready, run_req, step_req);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_phase",      32'(phase),       32'(m.ph));
        check("model_halted",     32'(halted),      32'(m.mode == M_HALT));
        check("model_instr_done", 32'(instr_done),  32'(m.done));
        check("model_retired",    32'(retired),     32'(sat(m.wraps, 65535)));
        check("model_phase2",     32'(phase2),      32'(m.ph));
        check("model_halted2",    32'(halted2),     32'(m.mode == M_HALT));
        check("model_done2",      32'(instr_done2), 32'(m.done));
        check("model_retired2",   32'(retired2),    32'(sat(m.wraps, 3)));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; halt = 1'b0; mem_ready = 1'b1; run_req = 1'b0; step_req = 1'b0;
        tick(2);
        check("reset_phase",   32'(phase),      32'd0);
        check("reset_halted",  32'(halted),     32'd0);
        check("reset_done",    32'(instr_done), 32'd0);
        check("reset_retired", 32'(retired),    32'd0);

        // First instruction from reset
        rst = 1'b1;
        tick(7);
        check("first_phase7", 32'(phase), 32'd7);
        tick(1);
        check("wrap_phase0",   32'(phase),      32'd0);
        check("wrap_done",     32'(instr_done), 32'd1);
        check("wrap_retired1", 32'(retired),    32'd1);
        tick(1);
        check("done_one_cycle", 32'(instr_done), 32'd0);
        check("after_wrap_ph1", 32'(phase),      32'd1);

        // Stall at phase 5 holds; at phase 3 it is ignored
        tick(4);
        mem_ready = 1'b0;
        tick(3);
        check("stall5_hold", 32'(phase), 32'd5);
        mem_ready = 1'b1;
        tick(1);
        check("stall5_release", 32'(phase), 32'd6);
        tick(5);
        mem_ready = 1'b0;
        tick(1);
        check("stall3_ignored", 32'(phase), 32'd4);
        mem_ready = 1'b1;

        // Halt at phase 4, ignored further halts, run resumes
        halt = 1'b1;
        tick(1);
        check("halt_phase5", 32'(phase),  32'd5);
        check("halt_flag",   32'(halted), 32'd1);
        tick(3);
        check("halt_held_phase", 32'(phase), 32'd5);
        halt = 1'b0;
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        check("run_phase6",  32'(phase),  32'd6);
        check("run_unhalt",  32'(halted), 32'd0);
        tick(2);
        check("run_wrap_ph",  32'(phase),   32'd0);
        check("run_retired3", 32'(retired), 32'd3);

        // step_req outside HALTED is ignored
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        check("step_ignored", 32'(halted), 32'd0);
        tick(3);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("halt2_phase5", 32'(phase), 32'd5);

        // Single step from phase 5 to the next boundary
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        check("step_phase6", 32'(phase), 32'd6);
        tick(2);
        check("step_end_ph",      32'(phase),   32'd0);
        check("step_end_halted",  32'(halted),  32'd1);
        check("step_end_retired", 32'(retired), 32'd4);
        tick(2);
        check("step_idle_ph", 32'(phase), 32'd0);

        // Full-instruction step
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        check("step2_ph1",    32'(phase),  32'd1);
        check("step2_unhalt", 32'(halted), 32'd0);
        tick(7);
        check("step2_ph0",      32'(phase),   32'd0);
        check("step2_halted",   32'(halted),  32'd1);
        check("step2_retired5", 32'(retired), 32'd5);

        // Halt at phase 4 pre-empts the step boundary
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(3);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("step_halt_ph5",  32'(phase),   32'd5);
        check("step_halt_flag", 32'(halted),  32'd1);
        check("step_halt_ret",  32'(retired), 32'd5);

        // run_req and step_req together take RUN
        run_req = 1'b1; step_req = 1'b1;
        tick(1);
        run_req = 1'b0; step_req = 1'b0;
        check("both_ph6", 32'(phase), 32'd6);
        tick(2);
        check("both_wrap_ph",  32'(phase),   32'd0);
        check("both_no_halt",  32'(halted),  32'd0);
        check("both_retired6", 32'(retired), 32'd6);
        tick(1);
        check("both_runs_on", 32'(phase), 32'd1);
        check("sat_retired2", 32'(retired2), 32'd3);

        // Reset in the middle of a phase-1 stall
        mem_ready = 1'b0;
        tick(2);
        check("stall1_hold", 32'(phase), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_phase",   32'(phase),   32'd0);
        check("midrst_retired", 32'(retired), 32'd0);
        check("midrst_done",    32'(instr_done), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        check("postrst_phase3",  32'(phase),    32'd3);
        check("postrst_retired", 32'(retired2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: WIDTH, 3, width of the phase bus; fixed at 3 (8 phases).
REQ-002 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 halt  input  1  halt request from the controller; sampled only at phase 4.
REQ-006 mem_ready  input  1  memory ready; low stalls the read phases 1 and 5.
REQ-007 run_req  input  1  single-cycle pulse; resumes free-running execution from HALTED.
REQ-008 step_req  input  1  single-cycle pulse; executes up to the next instruction boundary from HALTED.
REQ-009 phase  output  WIDTH  current phase, 0..7, fed to the controller.
REQ-010 halted  output  1  high while in state HALTED.
REQ-011 instr_done  output  1  registered one-cycle pulse after each 7->0 wrap.
REQ-012 retired  output  CNT_W  count of completed instructions.

Function
REQ-013 States SHALL be RUN, STEP and HALTED, encoded in 2 bits.
REQ-014 In RUN or STEP, phase SHALL advance by 1 per cycle and wrap from 7 to 0, except for the stall and halt cases below.
REQ-015 If phase is 1 or 5 and mem_ready=0, phase SHALL hold; stall length is unbounded.
REQ-016 mem_ready SHALL be ignored at all other phases.
REQ-017 In RUN or STEP with phase=4 and halt=1, the next edge SHALL set phase=5 and state=HALTED, so inc_pc is applied exactly once.
REQ-018 In HALTED, phase SHALL hold; the controller outputs for HLT at phase 5 are inert.
REQ-019 In HALTED, halt SHALL be ignored.
REQ-020 In HALTED, run_req=1 SHALL set state=RUN, and phase SHALL advance on that same edge.
REQ-021 In HALTED, step_req=1 with run_req=0 SHALL set state=STEP, and phase SHALL advance on that same edge.
REQ-022 run_req and step_req asserted together SHALL take RUN.
REQ-023 In STEP, the 7->0 wrap SHALL set state=HALTED with phase=0.
REQ-024 In STEP, a halt at phase 4 SHALL take priority per REQ-017.
REQ-025 run_req and step_req SHALL be ignored outside HALTED.
REQ-026 Each 7->0 wrap SHALL increment retired, saturating at 2^CNT_W-1, and assert instr_done on the following cycle for exactly one cycle.
REQ-027 No wrap SHALL occur while stalled or halted.
REQ-028 halted SHALL be registered state, not a combinational decode.

Reset
REQ-029 rst=0 SHALL asynchronously force phase=0, state=RUN, halted=0, instr_done=0 and retired=0.
REQ-030 Deassertion SHALL begin fetch at phase 0 on the first rising edge.
REQ-031 Reset mid-stall or mid-STEP SHALL discard all pending state, with no instr_done pulse.

Structure
REQ-032 The shared package SHALL hold the phase constants: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
REQ-033 The shared package SHALL also hold the state encoding and the opcode constants (HLT=0 ... JMP=7) shared with the controller.
REQ-034 The sequencer SHALL contain one sub-module, sat_counter (CNT_W-bit, enable-increment, saturating), used for retired.

Verification
REQ-035 Release reset, mem_ready=1, halt=0 -> phase 0,1,...,7,0; instr_done high one cycle after wrap; retired=1.
REQ-036 Hold mem_ready=0 for 3 cycles at phase 5 -> phase holds at 5 for 3 cycles, then 6; same stall check at phase 3 -> no hold.
REQ-037 halt=1 at phase 4 -> next edge phase=5, halted=1; further halt pulses -> no change; run_req -> 6, 7, 0, retired increments.
REQ-038 From HALTED at phase 5, pulse step_req -> phases 6, 7, 0, then halted=1 with phase=0; a second step_req -> phases 1..7, 0, then halted=1 again.
REQ-039 In HALTED, pulse run_req and step_req together -> state RUN, no halt at the next wrap.
REQ-040 Preload retired=0xFFFE, run 3 instructions -> retired=0xFFFF, held; assert rst mid-stall at phase 1 -> immediate phase=0, retired=0.
